// File: rtl/nios_sd_loader_ctrl_out_pkg.sv
// Shared constants and types for the SD-loader control output port:
// register addresses, STATUS bit positions and the pulse FSM states.
package nios_sd_loader_ctrl_out_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_PLEN   = 3'd1;
   localparam logic [2:0] ADDR_PULSE  = 3'd2;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

   localparam int BUSY_BIT = 31;
   localparam int OVR_BIT  = 30;

   typedef enum logic {
      IDLE,
      ACTIVE
   } pulse_state_t;

endpackage

// File: rtl/nios_sd_loader_pulse_timer.sv
// Hardware-timed pulse generator: holds the inversion mask for exactly
// max(len,1) cycles after an accepted start, and flags starts that arrive while busy.
module nios_sd_loader_pulse_timer
   import nios_sd_loader_ctrl_out_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] mask,
   input  logic [15:0]           len,
   output logic [DATA_WIDTH-1:0] mask_q,
   output logic [DATA_WIDTH-1:0] mask_next,
   output logic                  busy,
   output logic                  overrun
);

   pulse_state_t state_reg, state_next;
   logic [15:0]  cnt_reg, cnt_next;
   logic         ovr_reg, ovr_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         mask_q    <= '0;
         ovr_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         mask_q    <= mask_next;
         ovr_reg   <= ovr_next;
      end
   end

   // cnt counts the cycles still to go after the current one, so a length of
   // L keeps the mask up for L cycles; a zero length behaves as one cycle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      mask_next  = mask_q;
      ovr_next   = ovr_reg;
      case (state_reg)
         IDLE: begin
            if (start && (mask != '0)) begin
               mask_next  = mask;
               cnt_next   = (len == 16'd0) ? 16'd0 : len - 16'd1;
               ovr_next   = 1'b0;
               state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            if (start) begin
               ovr_next = 1'b1;
            end
            if (cnt_reg == 16'd0) begin
               mask_next  = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - 16'd1;
            end
         end
      endcase
   end

   assign busy    = (state_reg == ACTIVE);
   assign overrun = ovr_reg;

endmodule

// File: rtl/nios_sd_loader_ctrl_out.sv
// Avalon-MM control output port for the ZX core: level, set/clear and timed
// pulse writes drive a registered out_port; reads have one cycle of latency.
module nios_sd_loader_ctrl_out
   import nios_sd_loader_ctrl_out_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0,
   parameter logic [15:0]           PULSE_DEFAULT = 16'd1000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   logic                  wr;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   logic [15:0]           plen_reg, plen_next;
   logic [DATA_WIDTH-1:0] mask_q, mask_next;
   logic                  busy, overrun;
   logic [31:0]           rd_mux;
   logic                  unused_wd;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[DATA_WIDTH-1:0];
   assign unused_wd = ^writedata[31:16];

   always_comb begin
      data_next = data_reg;
      plen_next = plen_reg;
      if (wr) begin
         case (address)
            ADDR_DATA:   data_next = wd;
            ADDR_PLEN:   plen_next = writedata[15:0];
            ADDR_OUTSET: data_next = data_reg | wd;
            ADDR_OUTCLR: data_next = data_reg & ~wd;
            default:     ;
         endcase
      end
   end

   nios_sd_loader_pulse_timer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (wr && (address == ADDR_PULSE)),
      .mask      (wd),
      .len       (plen_reg),
      .mask_q    (mask_q),
      .mask_next (mask_next),
      .busy      (busy),
      .overrun   (overrun)
   );

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:  rd_mux[DATA_WIDTH-1:0] = data_reg;
         ADDR_PLEN:  rd_mux[15:0]           = plen_reg;
         ADDR_PULSE: begin
            rd_mux[DATA_WIDTH-1:0] = mask_q;
            rd_mux[OVR_BIT]        = overrun;
            rd_mux[BUSY_BIT]       = busy;
         end
         default:    rd_mux = '0;
      endcase
   end

   // out_port is built from next-state values so it moves on the same edge
   // that captures the write or ends the pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= RESET_VALUE;
         plen_reg <= PULSE_DEFAULT;
         readdata <= '0;
         out_port <= RESET_VALUE;
      end else begin
         data_reg <= data_next;
         plen_reg <= plen_next;
         readdata <= rd_mux;
         out_port <= data_next ^ mask_next;
      end
   end

endmodule

// File: tb/tb_nios_sd_loader_ctrl_out.sv
// Directed and randomized checks of the control output port against a
// cycle-level behavioural model of its register map and pulse timing.
module tb_nios_sd_loader_ctrl_out;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [3:0]  out_port;

   int checks = 0;
   int errors = 0;

   // behavioural model
   logic [3:0]  m_data;
   logic [15:0] m_plen;
   int          m_rem;
   logic [3:0]  m_mask;
   logic        m_ovr;
   logic [31:0] m_rd;
   logic [3:0]  m_out;

   nios_sd_loader_ctrl_out #(
      .DATA_WIDTH    (4),
      .RESET_VALUE   (4'h5),
      .PULSE_DEFAULT (16'd1000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_data = 4'h5;
      m_plen = 16'd1000;
      m_rem  = 0;
      m_mask = 4'h0;
      m_ovr  = 1'b0;
      m_rd   = 32'd0;
      m_out  = 4'h5;
   endtask

   // One clock edge of the model; m_rem is the number of cycles the pulse
   // mask is still visible on out_port after this edge.
   task automatic model_edge(input logic [2:0] a, input logic w, input logic [31:0] d);
      bit busy_pre;
      busy_pre = (m_rem > 0);
      case (a)
         3'd0:    m_rd = {28'd0, m_data};
         3'd1:    m_rd = {16'd0, m_plen};
         3'd2:    m_rd = {busy_pre, m_ovr, 26'd0, m_mask};
         default: m_rd = 32'd0;
      endcase
      if (busy_pre) begin
         m_rem--;
         if (m_rem == 0) m_mask = 4'h0;
      end
      if (w && a == 3'd2) begin
         if (busy_pre) m_ovr = 1'b1;
         else if (d[3:0] != 4'h0) begin
            m_rem  = (m_plen == 16'd0) ? 1 : int'(m_plen);
            m_mask = d[3:0];
            m_ovr  = 1'b0;
         end
      end
      if (w) begin
         case (a)
            3'd0: m_data = d[3:0];
            3'd1: m_plen = d[15:0];
            3'd4: m_data = m_data | d[3:0];
            3'd5: m_data = m_data & ~d[3:0];
            default: ;
         endcase
      end
      m_out = m_data ^ ((m_rem > 0) ? m_mask : 4'h0);
   endtask

   task automatic step(input string tag, input logic [2:0] a, input logic cs,
                       input logic wn, input logic [31:0] d);
      address    = a;
      chipselect = cs;
      write_n    = wn;
      writedata  = d;
      model_edge(a, cs & ~wn, d);
      @(posedge clk);
      #1;
      $display("%-10s a=%0d cs=%0b wn=%0b wd=%08h -> out=%h rd=%08h", tag, a, cs, wn, d, out_port, readdata);
      chk($sformatf("%s.out", tag), {28'd0, out_port}, {28'd0, m_out});
      chk($sformatf("%s.rd", tag), readdata, m_rd);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      int hi;
      logic [2:0]  ra;
      logic [31:0] rw;

      model_reset();
      #12;
      chk("rst.out", {28'd0, out_port}, 32'h5);
      chk("rst.rd", readdata, 32'd0);
      reset_n = 1'b1;

      step("rd_plen", 3'd1, 1'b1, 1'b1, 32'd0);
      chk("plen_def", readdata, 32'd1000);

      // level, set and clear writes
      step("wr_data", 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFA);
      chk("data_A", {28'd0, out_port}, 32'hA);
      step("outset", 3'd4, 1'b1, 1'b0, 32'h1);
      chk("set_B", {28'd0, out_port}, 32'hB);
      step("outclr", 3'd5, 1'b1, 1'b0, 32'h8);
      chk("clr_3", {28'd0, out_port}, 32'h3);
      step("rd_data", 3'd0, 1'b1, 1'b1, 32'd0);
      chk("rd_3", readdata, 32'h3);
      step("rd_set", 3'd4, 1'b1, 1'b1, 32'd0);
      chk("rd_set0", readdata, 32'h0);

      // 5-cycle pulse with an overrunning start in the middle
      step("wr_data0", 3'd0, 1'b1, 1'b0, 32'h0);
      step("wr_plen5", 3'd1, 1'b1, 1'b0, 32'd5);
      step("pulse1", 3'd2, 1'b1, 1'b0, 32'h1);
      hi = (out_port == 4'h1) ? 1 : 0;
      for (int k = 0; k < 7; k++) begin
         if (k == 0) begin
            step("pulse_ovr", 3'd2, 1'b1, 1'b0, 32'h2);
            chk("stat_act", readdata, 32'h8000_0001);
         end else begin
            step("rd_stat", 3'd2, 1'b1, 1'b1, 32'd0);
            if (k == 1) chk("stat_ovr", readdata, 32'hC000_0001);
         end
         if (out_port == 4'h1) hi++;
      end
      chk("pulse_len5", hi, 32'd5);
      chk("stat_end", readdata, 32'h4000_0000);

      // zero length means one cycle; accepted start clears overrun
      step("wr_plen0", 3'd1, 1'b1, 1'b0, 32'd0);
      step("pulse1c", 3'd2, 1'b1, 1'b0, 32'h1);
      chk("p1c_on", {28'd0, out_port}, 32'h1);
      step("rd_stat", 3'd2, 1'b1, 1'b1, 32'd0);
      chk("p1c_off", {28'd0, out_port}, 32'h0);
      chk("p1c_stat", readdata, 32'h8000_0001);
      step("rd_stat", 3'd2, 1'b1, 1'b1, 32'd0);
      chk("idle_stat", readdata, 32'h0);

      // zero mask is a no-op
      step("pulse0", 3'd2, 1'b1, 1'b0, 32'h0);
      chk("m0_out", {28'd0, out_port}, 32'h0);
      step("rd_stat", 3'd2, 1'b1, 1'b1, 32'd0);
      chk("m0_stat", readdata, 32'h0);

      // level change mid-pulse keeps the inversion
      step("wr_plen3", 3'd1, 1'b1, 1'b0, 32'd3);
      step("pulse1d", 3'd2, 1'b1, 1'b0, 32'h1);
      chk("pd_on", {28'd0, out_port}, 32'h1);
      step("wr_dataF", 3'd0, 1'b1, 1'b0, 32'hF);
      chk("pd_E1", {28'd0, out_port}, 32'hE);
      step("idle", 3'd0, 1'b0, 1'b1, 32'd0);
      chk("pd_E2", {28'd0, out_port}, 32'hE);
      step("idle", 3'd0, 1'b0, 1'b1, 32'd0);
      chk("pd_F", {28'd0, out_port}, 32'hF);

      // asynchronous reset in the middle of a pulse
      step("wr_plen10", 3'd1, 1'b1, 1'b0, 32'd10);
      step("pulse3", 3'd2, 1'b1, 1'b0, 32'h3);
      step("idle", 3'd2, 1'b0, 1'b1, 32'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("arst.out", {28'd0, out_port}, 32'h5);
      chk("arst.rd", readdata, 32'd0);
      model_reset();
      #2 reset_n = 1'b1;
      step("rd_plen", 3'd1, 1'b1, 1'b1, 32'd0);
      chk("arst.plen", readdata, 32'd1000);
      step("rd_stat", 3'd2, 1'b1, 1'b1, 32'd0);
      chk("arst.stat", readdata, 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         ra = 3'($urandom_range(0, 7));
         rw = $urandom();
         if (ra == 3'd1) rw = {rw[31:16], 16'($urandom_range(0, 6))};
         step("rand", ra, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rw);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
